// File: rtl/pine_bus_pkg.sv
// Shared definitions for the multiplexed external bus: widths and the
// slave controller's FSM state encoding.
package pine_bus_pkg;

   localparam int unsigned BUS_ADDR_W = 20;
   localparam int unsigned BUS_DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_REQ,
      ST_WAIT,
      ST_DONE
   } bus_state_e;

endpackage

// File: rtl/bus_slave_ctrl.sv
// Bus slave: demultiplexes AD/ALE, qualifies OE/WE strobes and turns each
// CPU bus cycle into one req/ack backend transaction with READY wait states.
module bus_slave_ctrl
   import pine_bus_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned ADDR_W      = BUS_ADDR_W
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic [BUS_DATA_W-1:0] ad_lo,
   input  logic [3:0]            ad_hi,
   input  logic                  ale,
   input  logic                  oe,
   input  logic                  we,
   input  logic                  pio,
   output logic [BUS_DATA_W-1:0] rdata,
   output logic                  rdata_en,
   output logic                  ready,
   output logic                  err,
   output logic [ADDR_W-1:0]     be_addr,
   output logic                  be_io,
   output logic                  be_req,
   output logic                  be_we,
   output logic [BUS_DATA_W-1:0] be_wdata,
   input  logic [BUS_DATA_W-1:0] be_rdata,
   input  logic                  be_ack
);

   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

   bus_state_e            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  abort_q, abort_d;
   logic [BUS_DATA_W-1:0] rdata_q, rdata_d;
   logic                  rdata_en_q, rdata_en_d;
   logic                  ready_q, ready_d;
   logic                  err_q, err_d;
   logic [ADDR_W-1:0]     be_addr_q, be_addr_d;
   logic                  be_io_q, be_io_d;
   logic                  be_req_q, be_req_d;
   logic                  be_we_q, be_we_d;
   logic [BUS_DATA_W-1:0] be_wdata_q, be_wdata_d;

   logic                  strobe_idle;
   logic                  abort_now;
   logic [3:0]            cnt_dec;

   assign strobe_idle = oe & we;
   assign cnt_dec     = (cnt_q == '0) ? '0 : cnt_q - 4'd1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      abort_d    = abort_q;
      rdata_d    = rdata_q;
      rdata_en_d = rdata_en_q;
      ready_d    = ready_q;
      err_d      = err_q;
      be_addr_d  = be_addr_q;
      be_io_d    = be_io_q;
      be_req_d   = be_req_q;
      be_we_d    = be_we_q;
      be_wdata_d = be_wdata_q;
      abort_now  = abort_q | strobe_idle;

      unique case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (ale) begin
               be_addr_d = ADDR_W'({ad_hi, ad_lo});
               be_io_d   = pio;
               state_d   = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (ale) begin
               be_addr_d = ADDR_W'({ad_hi, ad_lo});
               be_io_d   = pio;
            end else if (!strobe_idle) begin
               // Both strobes low is illegal; the write wins so data is not lost.
               be_we_d  = ~we;
               err_d    = err_q | (~oe & ~we);
               if (!we) be_wdata_d = ad_lo;
               be_req_d = 1'b1;
               cnt_d    = WAIT_CNT;
               abort_d  = 1'b0;
               state_d  = ST_REQ;
            end
         end
         ST_REQ: begin
            cnt_d   = cnt_dec;
            abort_d = abort_now;
            if (strobe_idle) err_d = 1'b1;
            if (be_ack) begin
               be_req_d = 1'b0;
               if (abort_now) begin
                  state_d = ST_IDLE;
               end else begin
                  if (!be_we_q) rdata_d = be_rdata;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (strobe_idle) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               ready_d    = 1'b1;
               rdata_en_d = ~be_we_q & ~oe;
               state_d    = ST_DONE;
            end else begin
               cnt_d = cnt_dec;
            end
         end
         ST_DONE: begin
            if (strobe_idle) begin
               ready_d    = 1'b0;
               rdata_en_d = 1'b0;
               if (ale) begin
                  be_addr_d = ADDR_W'({ad_hi, ad_lo});
                  be_io_d   = pio;
                  state_d   = ST_ADDR;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               rdata_en_d = ~be_we_q & ~oe;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         abort_q    <= 1'b0;
         rdata_q    <= '0;
         rdata_en_q <= 1'b0;
         ready_q    <= 1'b0;
         err_q      <= 1'b0;
         be_addr_q  <= '0;
         be_io_q    <= 1'b0;
         be_req_q   <= 1'b0;
         be_we_q    <= 1'b0;
         be_wdata_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         abort_q    <= abort_d;
         rdata_q    <= rdata_d;
         rdata_en_q <= rdata_en_d;
         ready_q    <= ready_d;
         err_q      <= err_d;
         be_addr_q  <= be_addr_d;
         be_io_q    <= be_io_d;
         be_req_q   <= be_req_d;
         be_we_q    <= be_we_d;
         be_wdata_q <= be_wdata_d;
      end
   end

   assign rdata    = rdata_q;
   assign rdata_en = rdata_en_q;
   assign ready    = ready_q;
   assign err      = err_q;
   assign be_addr  = be_addr_q;
   assign be_io    = be_io_q;
   assign be_req   = be_req_q;
   assign be_we    = be_we_q;
   assign be_wdata = be_wdata_q;

endmodule

// File: tb/tb_bus_slave_ctrl.sv
// Directed bench for bus_slave_ctrl: a vector table for read/write cycles plus
// hand-written sequences for wait states, back-to-back, errors and reset.
module tb_bus_slave_ctrl;

   logic        CLK;
   logic        nRST;
   logic [15:0] ad_lo;
   logic [3:0]  ad_hi;
   logic        ale, oe, we, pio;

   // main instance (WAIT_STATES=1), plus WAIT_STATES=4 and WAIT_STATES=0 instances
   logic [15:0] rdata_m, be_wdata_m, be_rdata_m;
   logic [19:0] be_addr_m;
   logic        rdata_en_m, ready_m, err_m, be_io_m, be_req_m, be_we_m, be_ack_m;
   logic [15:0] rdata_4, be_wdata_4, be_rdata_4;
   logic [19:0] be_addr_4;
   logic        rdata_en_4, ready_4, err_4, be_io_4, be_req_4, be_we_4, be_ack_4;
   logic [15:0] rdata_0, be_wdata_0, be_rdata_0;
   logic [19:0] be_addr_0;
   logic        rdata_en_0, ready_0, err_0, be_io_0, be_req_0, be_we_0, be_ack_0;

   logic [2:0]  ack_v;
   int          lat [3];
   int          n_chk = 0;
   int          n_mis = 0;
   int          req_rises = 0;

   assign be_ack_m = ack_v[0];
   assign be_ack_4 = ack_v[1];
   assign be_ack_0 = ack_v[2];
   assign be_rdata_4 = 16'h4444;
   assign be_rdata_0 = 16'h0000;

   bus_slave_ctrl #(.WAIT_STATES(1)) dut (
      .CLK(CLK), .nRST(nRST), .ad_lo(ad_lo), .ad_hi(ad_hi), .ale(ale), .oe(oe), .we(we),
      .pio(pio), .rdata(rdata_m), .rdata_en(rdata_en_m), .ready(ready_m), .err(err_m),
      .be_addr(be_addr_m), .be_io(be_io_m), .be_req(be_req_m), .be_we(be_we_m),
      .be_wdata(be_wdata_m), .be_rdata(be_rdata_m), .be_ack(be_ack_m));

   bus_slave_ctrl #(.WAIT_STATES(4)) dut_ws4 (
      .CLK(CLK), .nRST(nRST), .ad_lo(ad_lo), .ad_hi(ad_hi), .ale(ale), .oe(oe), .we(we),
      .pio(pio), .rdata(rdata_4), .rdata_en(rdata_en_4), .ready(ready_4), .err(err_4),
      .be_addr(be_addr_4), .be_io(be_io_4), .be_req(be_req_4), .be_we(be_we_4),
      .be_wdata(be_wdata_4), .be_rdata(be_rdata_4), .be_ack(be_ack_4));

   bus_slave_ctrl #(.WAIT_STATES(0)) dut_ws0 (
      .CLK(CLK), .nRST(nRST), .ad_lo(ad_lo), .ad_hi(ad_hi), .ale(ale), .oe(oe), .we(we),
      .pio(pio), .rdata(rdata_0), .rdata_en(rdata_en_0), .ready(ready_0), .err(err_0),
      .be_addr(be_addr_0), .be_io(be_io_0), .be_req(be_req_0), .be_we(be_we_0),
      .be_wdata(be_wdata_0), .be_rdata(be_rdata_0), .be_ack(be_ack_0));

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Backends: ack pulses so that it is sampled lat[i] edges after be_req rises
   initial begin
      int c [3];
      logic [2:0] req;
      ack_v = '0;
      for (int i = 0; i < 3; i++) c[i] = 0;
      forever begin
         @(negedge CLK);
         req = {be_req_0, be_req_4, be_req_m};
         for (int i = 0; i < 3; i++) begin
            ack_v[i] = 1'b0;
            if (req[i] && nRST) begin
               c[i]++;
               if (c[i] == lat[i]) ack_v[i] = 1'b1;
            end else begin
               c[i] = 0;
            end
         end
      end
   end

   always @(posedge be_req_m) req_rises++;

   typedef struct {
      logic        ale;
      logic [3:0]  hi;
      logic [15:0] lo;
      logic        oe;
      logic        we;
      logic        pio;
      int          lat;
      logic        x_ready;
      logic        x_rden;
      logic        x_req;
      logic        x_we;
      logic        x_io;
      logic [19:0] x_addr;
      logic [15:0] x_rdata;
      logic [15:0] x_wdata;
      logic        x_err;
   } vec_t;

   vec_t vecs [12];

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic bus(input logic a, input logic [3:0] h, input logic [15:0] l,
                      input logic o, input logic w, input logic p);
      ale = a; ad_hi = h; ad_lo = l; oe = o; we = w; pio = p;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!ready_m && n < 20) begin
         tick();
         n++;
      end
      chk(name, 64'(ready_m), 64'd1);
   endtask

   function automatic logic [63:0] outs_m();
      return 64'({ready_m, rdata_en_m, be_req_m, be_we_m, be_io_m, be_addr_m,
                  rdata_m, be_wdata_m, err_m});
   endfunction

   initial begin
      int a0, r4, r0, r1, rises0, n;

      // read {3,1234}, backend acks 2 edges after be_req, data BEEF
      vecs[0]  = '{1'b1, 4'h3, 16'h1234, 1'b1, 1'b1, 1'b0, 2, 0,0,0,0,0, 20'h31234, 16'h0000, 16'h0000, 0};
      vecs[1]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 2, 0,0,1,0,0, 20'h31234, 16'h0000, 16'h0000, 0};
      vecs[2]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 2, 0,0,1,0,0, 20'h31234, 16'h0000, 16'h0000, 0};
      vecs[3]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 2, 0,0,0,0,0, 20'h31234, 16'hBEEF, 16'h0000, 0};
      vecs[4]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 2, 1,1,0,0,0, 20'h31234, 16'hBEEF, 16'h0000, 0};
      vecs[5]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 2, 1,1,0,0,0, 20'h31234, 16'hBEEF, 16'h0000, 0};
      vecs[6]  = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0, 2, 0,0,0,0,0, 20'h31234, 16'hBEEF, 16'h0000, 0};
      // I/O write to 00040 with data 00A5, 1-cycle ack; pio dropped after ale
      vecs[7]  = '{1'b1, 4'h0, 16'h0040, 1'b1, 1'b1, 1'b1, 1, 0,0,0,0,1, 20'h00040, 16'hBEEF, 16'h0000, 0};
      vecs[8]  = '{1'b0, 4'h0, 16'h00A5, 1'b1, 1'b0, 1'b0, 1, 0,0,1,1,1, 20'h00040, 16'hBEEF, 16'h00A5, 0};
      vecs[9]  = '{1'b0, 4'h0, 16'h00A5, 1'b1, 1'b0, 1'b0, 1, 0,0,0,1,1, 20'h00040, 16'hBEEF, 16'h00A5, 0};
      vecs[10] = '{1'b0, 4'h0, 16'h00A5, 1'b1, 1'b0, 1'b0, 1, 1,0,0,1,1, 20'h00040, 16'hBEEF, 16'h00A5, 0};
      vecs[11] = '{1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0, 1, 0,0,0,1,1, 20'h00040, 16'hBEEF, 16'h00A5, 0};

      lat[0] = 2; lat[1] = 1; lat[2] = 3;
      be_rdata_m = 16'hBEEF;
      nRST = 1'b0;
      bus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0);
      tick(); tick();
      chk("reset_state", outs_m(), 64'd0);
      nRST = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         lat[0] = vecs[i].lat;
         bus(vecs[i].ale, vecs[i].hi, vecs[i].lo, vecs[i].oe, vecs[i].we, vecs[i].pio);
         tick();
         chk($sformatf("vec%0d", i), outs_m(),
             64'({vecs[i].x_ready, vecs[i].x_rden, vecs[i].x_req, vecs[i].x_we, vecs[i].x_io,
                  vecs[i].x_addr, vecs[i].x_rdata, vecs[i].x_wdata, vecs[i].x_err}));
      end
      tick(); tick(); tick();

      // READY latency from strobe qualification across the three wait-state settings
      lat[0] = 1;
      be_rdata_m = 16'hC0DE;
      bus(1'b1, 4'h0, 16'h0100, 1'b1, 1'b1, 1'b0);
      tick();
      bus(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0);
      tick();
      a0 = 0; r4 = 0; r0 = 0; r1 = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (be_ack_0 && a0 == 0) a0 = i;
         if (ready_4 && r4 == 0) r4 = i;
         if (ready_0 && r0 == 0) r0 = i;
         if (ready_m && r1 == 0) r1 = i;
      end
      chk("ws4_ready_latency", 64'(r4), 64'd5);
      chk("ws0_ready_latency", 64'(r0), 64'd4);
      chk("ws0_ready_after_ack", 64'(r0), 64'(a0 + 1));
      chk("ws1_ready_latency", 64'(r1), 64'd2);
      chk("ws1_rdata", 64'(rdata_m), 64'h0000_C0DE);
      bus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0);
      tick(); tick();

      // back-to-back: read 50010, then ale during DONE starts write to 50020
      be_rdata_m = 16'h1357;
      bus(1'b1, 4'h5, 16'h0010, 1'b1, 1'b1, 1'b0);
      tick();
      rises0 = req_rises;
      bus(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0);
      tick();
      wait_ready("b2b_ready1");
      bus(1'b1, 4'h5, 16'h0020, 1'b1, 1'b1, 1'b0);
      tick();
      chk("b2b_relatch", 64'({ready_m, rdata_en_m, be_addr_m, rdata_m}),
          64'({1'b0, 1'b0, 20'h50020, 16'h1357}));
      bus(1'b0, 4'h0, 16'h1111, 1'b1, 1'b0, 1'b0);
      tick();
      chk("b2b_write_req", 64'({be_req_m, be_we_m, be_wdata_m}), 64'({1'b1, 1'b1, 16'h1111}));
      wait_ready("b2b_ready2");
      bus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0);
      tick();
      chk("b2b_two_requests", 64'(req_rises - rises0), 64'd2);
      chk("b2b_no_err", 64'(err_m), 64'd0);

      // oe and we low together: error, performed as a write
      bus(1'b1, 4'h1, 16'h0002, 1'b1, 1'b1, 1'b0);
      tick();
      bus(1'b0, 4'h0, 16'h7777, 1'b0, 1'b0, 1'b0);
      tick();
      chk("both_low", 64'({err_m, be_we_m, be_req_m, be_wdata_m}),
          64'({1'b1, 1'b1, 1'b1, 16'h7777}));
      wait_ready("both_low_ready");
      chk("both_low_no_rden", 64'(rdata_en_m), 64'd0);
      bus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0);
      tick();

      // asynchronous reset while the backend request is outstanding
      lat[0] = 5;
      bus(1'b1, 4'h2, 16'h0ABC, 1'b1, 1'b1, 1'b0);
      tick();
      bus(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0);
      tick();
      chk("rst_pre_req", 64'(be_req_m), 64'd1);
      #2 nRST = 1'b0;
      #1;
      chk("rst_async_outputs", outs_m(), 64'd0);
      bus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0);
      tick(); tick();
      nRST = 1'b1;
      tick(); tick(); tick();
      chk("rst_req_abandoned", 64'({be_req_m, ready_m}), 64'd0);

      // clean read, then a read whose strobe is released while in REQ
      lat[0] = 3;
      be_rdata_m = 16'h2468;
      bus(1'b1, 4'h3, 16'h0300, 1'b1, 1'b1, 1'b0);
      tick();
      bus(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0);
      tick();
      wait_ready("read2_ready");
      bus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0);
      tick();
      chk("read2_data", 64'({err_m, rdata_m}), 64'({1'b0, 16'h2468}));
      be_rdata_m = 16'hDEAD;
      bus(1'b1, 4'h3, 16'h0304, 1'b1, 1'b1, 1'b0);
      tick();
      bus(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0);
      tick();
      bus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0);
      tick();
      chk("abort_err", 64'(err_m), 64'd1);
      n = 0;
      while (be_req_m && n < 10) begin
         tick();
         n++;
      end
      chk("abort_ack_done", 64'(be_req_m), 64'd0);
      chk("abort_discard", 64'({ready_m, rdata_en_m, rdata_m}), 64'({1'b0, 1'b0, 16'h2468}));
      tick();
      chk("abort_no_ready", 64'({ready_m, rdata_en_m}), 64'd0);
      bus(1'b1, 4'h3, 16'h0308, 1'b1, 1'b1, 1'b0);
      tick();
      chk("abort_back_idle", 64'(be_addr_m), 64'h30308);
      bus(1'b0, 4'h0, 16'h0000, 1'b1, 1'b1, 1'b0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_mis);
      $finish;
   end

endmodule
